// File: rtl/color_palette_dbuf.sv
// Double-buffered colour palette: the host fills a shadow bank, and a commit swaps it
// in at the next frame boundary; the pixel path reads the active bank with one cycle of latency.
module color_palette_dbuf #(
    parameter  int unsigned WIDTH = 24,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             iwr,
    input  logic [AW-1:0]    iwaddr,
    input  logic [WIDTH-1:0] iwdata,
    output logic             owr_ready,
    input  logic             icommit,
    input  logic             iframe,
    input  logic             ird,
    input  logic [AW-1:0]    iraddr,
    output logic [WIDTH-1:0] ordata,
    output logic             ordata_valid,
    output logic             ocommit_pending,
    output logic             obank
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SYNC    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_bank [2][DEPTH];
    logic             r_bank_sel;
    logic [AW-1:0]    r_sync_cnt;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rdata_valid;

    logic w_shadow_sel;
    logic w_wr_in_range;
    logic w_rd_in_range;
    logic w_sync_last;
    logic w_wr_en;
    logic w_swap;
    logic w_sync_act;

    assign w_shadow_sel  = ~r_bank_sel;
    assign w_wr_in_range = 32'(iwaddr) < DEPTH;
    assign w_rd_in_range = 32'(iraddr) < DEPTH;
    assign w_sync_last   = (r_sync_cnt == AW'(DEPTH - 1));

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (icommit)     w_state_nxt = ST_PENDING;
            ST_PENDING: if (iframe)      w_state_nxt = ST_SYNC;
            ST_SYNC:    if (w_sync_last) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    // Shadow is writable only in IDLE; a same-cycle commit still takes the write.
    always_comb begin
        owr_ready       = 1'b0;
        ocommit_pending = 1'b0;
        w_swap          = 1'b0;
        w_sync_act      = 1'b0;
        case (r_state)
            ST_IDLE:    owr_ready = 1'b1;
            ST_PENDING: begin
                ocommit_pending = 1'b1;
                w_swap          = iframe;
            end
            ST_SYNC:    begin
                ocommit_pending = 1'b1;
                w_sync_act      = 1'b1;
            end
            default:    owr_ready = 1'b0;
        endcase
        w_wr_en = owr_ready & iwr & w_wr_in_range;
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            r_bank_sel <= 1'b0;
            r_sync_cnt <= '0;
        end else begin
            if (w_swap) begin
                r_bank_sel <= ~r_bank_sel;
            end
            if (w_sync_act) begin
                r_sync_cnt <= w_sync_last ? '0 : r_sync_cnt + AW'(1);
            end
        end
    end

    // After a swap, the new shadow is refilled from the new active bank one entry per cycle.
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    r_bank[b][e] <= '0;
                end
            end
        end else if (w_wr_en) begin
            r_bank[w_shadow_sel][iwaddr] <= iwdata;
        end else if (w_sync_act) begin
            r_bank[w_shadow_sel][r_sync_cnt] <= r_bank[r_bank_sel][r_sync_cnt];
        end
    end

    // The read samples the bank select before any toggle on the same edge.
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= ird;
            if (ird) begin
                r_rdata <= w_rd_in_range ? r_bank[r_bank_sel][iraddr] : '0;
            end
        end
    end

    assign ordata       = r_rdata;
    assign ordata_valid = r_rdata_valid;
    assign obank        = r_bank_sel;

endmodule

// File: tb/tb_color_palette_dbuf.sv
// Bench for color_palette_dbuf: DEPTH=4 and DEPTH=5 instances share one stimulus stream
// and are checked against a bank-level palette model with a read-data scoreboard.
module tb_color_palette_dbuf;

    localparam int unsigned W = 24;

    logic         iclk = 1'b0;
    logic         irst_n;
    logic         iwr;
    logic [2:0]   waddr;
    logic [W-1:0] iwdata;
    logic         icommit;
    logic         iframe;
    logic         ird;
    logic [2:0]   raddr;

    logic         ready4, pend4, bank4, valid4;
    logic [W-1:0] rdata4;
    logic         ready5, pend5, bank5, valid5;
    logic [W-1:0] rdata5;

    always #5 iclk = ~iclk;

    color_palette_dbuf #(.WIDTH(W), .DEPTH(4)) u_dut4 (
        .iclk            (iclk),
        .irst_n          (irst_n),
        .iwr             (iwr),
        .iwaddr          (waddr[1:0]),
        .iwdata          (iwdata),
        .owr_ready       (ready4),
        .icommit         (icommit),
        .iframe          (iframe),
        .ird             (ird),
        .iraddr          (raddr[1:0]),
        .ordata          (rdata4),
        .ordata_valid    (valid4),
        .ocommit_pending (pend4),
        .obank           (bank4)
    );

    color_palette_dbuf #(.WIDTH(W), .DEPTH(5)) u_dut5 (
        .iclk            (iclk),
        .irst_n          (irst_n),
        .iwr             (iwr),
        .iwaddr          (waddr),
        .iwdata          (iwdata),
        .owr_ready       (ready5),
        .icommit         (icommit),
        .iframe          (iframe),
        .ird             (ird),
        .iraddr          (raddr),
        .ordata          (rdata5),
        .ordata_valid    (valid5),
        .ocommit_pending (pend5),
        .obank           (bank5)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: what the pixel path sees (active) and what the next commit will publish (shadow).
    logic [W-1:0] m_act [2][8];
    logic [W-1:0] m_shd [2][8];
    int           m_state [2];   // 0 idle, 1 waiting for frame, 2 mirroring
    int           m_left  [2];
    logic         m_bank  [2];
    int           m_depth [2] = '{4, 5};
    logic [W-1:0] q4 [$];
    logic [W-1:0] q5 [$];
    bit           armed = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        int           wa;
        int           ra;
        logic [W-1:0] e;
        wa = (d == 0) ? int'(waddr[1:0]) : int'(waddr);
        ra = (d == 0) ? int'(raddr[1:0]) : int'(raddr);
        if (!irst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_act[d][i] = '0;
                m_shd[d][i] = '0;
            end
            m_state[d] = 0;
            m_left[d]  = 0;
            m_bank[d]  = 1'b0;
            return;
        end
        if (ird) begin
            e = (ra < m_depth[d]) ? m_act[d][ra] : '0;
            if (d == 0) q4.push_back(e);
            else        q5.push_back(e);
        end
        case (m_state[d])
            0: begin
                if (iwr && wa < m_depth[d]) m_shd[d][wa] = iwdata;
                if (icommit) m_state[d] = 1;
            end
            1: begin
                if (iframe) begin
                    // Shadow is published; afterwards the shadow equals the new active content.
                    for (int i = 0; i < 8; i++) m_act[d][i] = m_shd[d][i];
                    m_bank[d]  = ~m_bank[d];
                    m_left[d]  = m_depth[d];
                    m_state[d] = 2;
                end
            end
            default: begin
                m_left[d] = m_left[d] - 1;
                if (m_left[d] == 0) m_state[d] = 0;
            end
        endcase
    endtask

    task automatic check_status();
        chk("ready4", W'(ready4), W'(m_state[0] == 0));
        chk("pend4",  W'(pend4),  W'(m_state[0] != 0));
        chk("bank4",  W'(bank4),  W'(m_bank[0]));
        chk("ready5", W'(ready5), W'(m_state[1] == 0));
        chk("pend5",  W'(pend5),  W'(m_state[1] != 0));
        chk("bank5",  W'(bank5),  W'(m_bank[1]));
    endtask

    task automatic cyc(input int rst, input int wr, input int wa, input logic [W-1:0] wd,
                       input int cm, input int fr, input int rd, input int ra);
        @(negedge iclk);
        if (armed) check_status();
        irst_n  = (rst == 0);
        iwr     = (wr != 0);
        waddr   = 3'(wa);
        iwdata  = wd;
        icommit = (cm != 0);
        iframe  = (fr != 0);
        ird     = (rd != 0);
        raddr   = 3'(ra);
        model_step(0);
        model_step(1);
        if (rst != 0) armed = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        cyc(0, 1, a, d, 0, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        cyc(0, 0, 0, '0, 0, 0, 1, a);
    endtask

    task automatic commit();
        cyc(0, 0, 0, '0, 1, 0, 0, 0);
    endtask

    task automatic frame();
        cyc(0, 0, 0, '0, 0, 1, 0, 0);
    endtask

    always @(posedge iclk) begin
        #1;
        if (valid4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd4: unexpected valid, data %h at %0t", rdata4, $time);
            end else begin
                chk("rd4", rdata4, q4.pop_front());
            end
        end
    end

    always @(posedge iclk) begin
        #1;
        if (valid5 === 1'b1) begin
            if (q5.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd5: unexpected valid, data %h at %0t", rdata5, $time);
            end else begin
                chk("rd5", rdata5, q5.pop_front());
            end
        end
    end

    initial begin
        irst_n = 1'b0; iwr = 1'b0; waddr = '0; iwdata = '0;
        icommit = 1'b0; iframe = 1'b0; ird = 1'b0; raddr = '0;

        // Reset, then read back cleared entries
        repeat (3) cyc(1, 0, 0, '0, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) rd(a);
        idle(1);

        // Double buffer: invisible until the frame boundary
        wr(2, 24'hFF0000);
        commit();
        rd(2);
        frame();
        rd(2);
        idle(5);

        // Writes while pending are dropped
        commit();
        wr(1, 24'h00FF00);
        frame();
        idle(5);
        rd(1);

        // Mirror: only addr0 changes across the second swap; read on the toggle edge uses old bank
        wr(1, 24'h111111);
        wr(2, 24'h222222);
        wr(3, 24'h333333);
        commit();
        idle(2);
        cyc(0, 0, 0, '0, 0, 1, 1, 2);
        idle(5);
        cyc(0, 1, 0, 24'hABCDEF, 1, 0, 0, 0);
        frame();
        idle(5);
        for (int a = 0; a < 4; a++) rd(a);

        // Commit and frame together: only the later frame swaps
        wr(3, 24'h0F0F0F);
        cyc(0, 0, 0, '0, 1, 1, 0, 0);
        idle(2);
        rd(3);
        frame();
        idle(6);
        rd(3);

        // Out-of-range address on the DEPTH=5 instance
        wr(6, 24'h666666);
        wr(4, 24'h444444);
        commit();
        frame();
        idle(6);
        rd(7); rd(6); rd(4); rd(2);

        // Reset in the middle of the mirror copy
        wr(0, 24'h123456);
        commit();
        frame();
        idle(2);
        cyc(1, 0, 0, '0, 0, 0, 0, 0);
        for (int a = 0; a < 5; a++) rd(a);
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0) ? 1 : 0,
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)),
                24'($urandom()),
                ($urandom_range(0, 7) == 0) ? 1 : 0,
                ($urandom_range(0, 5) == 0) ? 1 : 0,
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)));
        end
        idle(8);
        @(negedge iclk);
        check_status();
        chk("q4_drained", W'(q4.size()), '0);
        chk("q5_drained", W'(q5.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
